tl_ul_ram_responder: RTL and testbench
======================================

# tl_ul_ram_responder

TileLink-UL responder terminating the A/D channel pair driven by an upstream buffer or crossbar port. It accepts single-beat Get/PutFullData/PutPartialData requests into a 64-bit-wide register-file scratchpad. It returns one AccessAck, AccessAckData or HintAck per request through a one-entry D response register. It sits at the leaf of the peripheral bus as the slave end of the bus interface.

## Interface
- BASE_ADDR, 31'h0800_0000: byte base of the decoded window; aligned to window size.
- DEPTH, 512: number of 64-bit words; power of two, 2..4096; window = DEPTH*8 bytes.
- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all control state immediately.
- auto_in_a_ready  out  1  request accepted when high with a_valid.
- auto_in_a_valid  in  1  request valid.
- auto_in_a_bits_opcode  in  3  0 PutFull, 1 PutPartial, 2 Arith, 3 Logical, 4 Get, 5 Intent.
- auto_in_a_bits_param  in  3  ignored.
- auto_in_a_bits_size  in  2  log2 bytes; echoed on D.
- auto_in_a_bits_source  in  9  echoed on D.
- auto_in_a_bits_address  in  31  byte address.
- auto_in_a_bits_mask  in  8  byte lanes written.
- auto_in_a_bits_data  in  64  write data.
- auto_in_a_bits_corrupt  in  1  1 suppresses the write; the ack still returns.
- auto_in_d_ready  in  1  response consumed.
- auto_in_d_valid  out  1  response valid.
- auto_in_d_bits_opcode  out  3  0 AccessAck, 1 AccessAckData, 2 HintAck.
- auto_in_d_bits_param  out  2  constant 0.
- auto_in_d_bits_size  out  2  captured request size.
- auto_in_d_bits_source  out  9  captured request source.
- auto_in_d_bits_sink  out  1  constant 0.
- auto_in_d_bits_denied  out  1  error response.
- auto_in_d_bits_data  out  64  read data; 0 when not AccessAckData.
- auto_in_d_bits_corrupt  out  1  set with denied on data responses.

## Operation
- Response slot states: EMPTY (d_valid=0) and FULL (d_valid=1).
- a_ready = !d_valid | d_ready, combinational; A fire = a_valid & a_ready.
- EMPTY + A fire -> FULL. FULL + D fire with no A fire -> EMPTY. FULL + D fire + A fire in the same cycle -> stays FULL with the new response; no bubble.
- In-range condition: address[30:3] - BASE_ADDR[30:3] < DEPTH. Word index = address[3 +: log2(DEPTH)]. Address bits [2:0] are ignored for data.
- Get, in range -> AccessAckData with the full 64-bit word at the index, denied=0, corrupt=0.
- PutFull/PutPartial, in range -> for each i, mem byte i <= a_data byte i where mask[i]=1 and a_corrupt=0. Response is AccessAck, denied=0.
- Get, out of range -> AccessAckData, data=0, denied=1, corrupt=1.
- Put, out of range -> AccessAck, denied=1; no write.
- Arith/Logical -> AccessAckData, data=0, denied=1, corrupt=1; no write.
- Intent -> HintAck, denied=0.
- Opcodes 6 and 7 -> AccessAck, denied=1.
- Memory array is not reset; contents are undefined until written.

## Timing
- Write commits at the A fire edge.
- Read data is sampled in the A fire cycle and registered into the slot. D appears the cycle after A fire: latency 1.
- A Get that fires the cycle after a Put to the same word returns the new data.
- A Get and a Put cannot fire in the same cycle, since there is one A channel.
- Throughput is 1 request/cycle while d_ready stays high.
- D payload is held stable while d_valid=1 and d_ready=0.
- Reset values, asserted asynchronously: d_valid=0, opcode=0, size=0, source=0, denied=0, corrupt=0, data=0. a_ready=1 during and after reset.
- Reset mid-operation drops a pending response; no D is issued for that request.
- Deassertion of reset is synchronized externally. The first A can fire on the first edge after deassertion.

## Test plan
- Reset while FULL (d_ready=0): drive reset=0 mid-cycle -> d_valid falls with no clock edge; after release, a_ready=1 and d_valid=0.
- PutFull addr=BASE+0x10, data=0x1122334455667788, mask=0xFF, source=0x1A5; then Get same address -> AccessAck src 0x1A5, then AccessAckData data 0x1122334455667788, each 1 cycle after its A fire.
- PutPartial mask=0x0F, data=0xFFFFFFFF_AAAAAAAA over the prior word -> Get returns 0x11223344AAAAAAAA.
- Back-to-back Gets, d_ready=1 -> a_ready stays 1 and one response per cycle, in order. Then d_ready=0 for 3 cycles -> a_ready=0 and D payload held constant.
- Get addr=BASE+DEPTH*8 -> AccessAckData with denied=1, corrupt=1, data=0. Put to the same address -> AccessAck with denied=1, and an in-range word read afterwards is unchanged.
- Opcode 2 -> AccessAckData denied=1, no write. Opcode 5 -> HintAck denied=0. PutFull with a_corrupt=1 -> AccessAck, memory unchanged.

Source files
------------

// File: rtl/tl_ul_ram_responder.sv
// tl_ul_ram_responder: TileLink-UL leaf responder backed by a 64-bit word scratchpad.
// One-entry D slot; reads are registered so D trails A fire by one cycle.
module tl_ul_ram_responder #(
   parameter logic [30:0] BASE_ADDR = 31'h0800_0000,
   parameter int          DEPTH     = 512
) (
   input  logic        clock,
   input  logic        reset,
   output logic        auto_in_a_ready,
   input  logic        auto_in_a_valid,
   input  logic [2:0]  auto_in_a_bits_opcode,
   input  logic [2:0]  auto_in_a_bits_param,
   input  logic [1:0]  auto_in_a_bits_size,
   input  logic [8:0]  auto_in_a_bits_source,
   input  logic [30:0] auto_in_a_bits_address,
   input  logic [7:0]  auto_in_a_bits_mask,
   input  logic [63:0] auto_in_a_bits_data,
   input  logic        auto_in_a_bits_corrupt,
   input  logic        auto_in_d_ready,
   output logic        auto_in_d_valid,
   output logic [2:0]  auto_in_d_bits_opcode,
   output logic [1:0]  auto_in_d_bits_param,
   output logic [1:0]  auto_in_d_bits_size,
   output logic [8:0]  auto_in_d_bits_source,
   output logic        auto_in_d_bits_sink,
   output logic        auto_in_d_bits_denied,
   output logic [63:0] auto_in_d_bits_data,
   output logic        auto_in_d_bits_corrupt
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [27:0] DEPTH_W = 28'(DEPTH);
   typedef enum logic {EMPTY, FULL} state_t;
   state_t state;
   logic [63:0] mem [DEPTH];
   logic [27:0] off;
   logic [AW-1:0] idx;
   logic [2:0] op, op_n;
   logic a_fire, in_range, is_put, is_get, is_atom, is_hint, denied_n, corrupt_n, wr_en;
   logic [63:0] data_n;
   logic unused;
   assign unused = ^{auto_in_a_bits_param, auto_in_a_bits_address[2:0]};
   assign auto_in_a_ready = (state == EMPTY) || auto_in_d_ready;
   assign auto_in_d_valid = (state == FULL);
   assign auto_in_d_bits_param = 2'd0;
   assign auto_in_d_bits_sink = 1'b0;
   assign a_fire = auto_in_a_valid && auto_in_a_ready;
   assign op = auto_in_a_bits_opcode;
   assign idx = auto_in_a_bits_address[3 +: AW];
   always_comb begin
      // Unsigned wrap makes addresses below the base land out of range too.
      off = auto_in_a_bits_address[30:3] - BASE_ADDR[30:3];
      in_range = off < DEPTH_W;
      is_put = (op == 3'd0) || (op == 3'd1);
      is_get = (op == 3'd4);
      is_atom = (op == 3'd2) || (op == 3'd3);
      is_hint = (op == 3'd5);
      op_n = (is_get || is_atom) ? 3'd1 : is_hint ? 3'd2 : 3'd0;
      denied_n = is_atom || (op > 3'd5) || ((is_get || is_put) && !in_range);
      corrupt_n = denied_n && (op_n == 3'd1);
      data_n = (is_get && in_range) ? mem[idx] : 64'd0;
      wr_en = a_fire && is_put && in_range && !auto_in_a_bits_corrupt;
   end
   always_ff @(posedge clock) begin
      if (wr_en)
         for (int i = 0; i < 8; i++)
            if (auto_in_a_bits_mask[i]) mem[idx][8*i +: 8] <= auto_in_a_bits_data[8*i +: 8];
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= EMPTY;
         auto_in_d_bits_opcode <= 3'd0;
         auto_in_d_bits_size <= 2'd0;
         auto_in_d_bits_source <= 9'd0;
         auto_in_d_bits_denied <= 1'b0;
         auto_in_d_bits_corrupt <= 1'b0;
         auto_in_d_bits_data <= 64'd0;
      end else if (a_fire) begin
         state <= FULL;
         auto_in_d_bits_opcode <= op_n;
         auto_in_d_bits_size <= auto_in_a_bits_size;
         auto_in_d_bits_source <= auto_in_a_bits_source;
         auto_in_d_bits_denied <= denied_n;
         auto_in_d_bits_corrupt <= corrupt_n;
         auto_in_d_bits_data <= data_n;
      end else if (auto_in_d_ready) begin
         state <= EMPTY;
      end
   end
endmodule

// File: tb/tb_tl_ul_ram_responder.sv
// tb_tl_ul_ram_responder: directed and random TL-UL traffic against a word-array
// reference model with an expected-response queue.
module tb_tl_ul_ram_responder;
   localparam logic [30:0] BASE = 31'h0800_0000;
   localparam int DEPTH = 512;
   logic clock = 1'b0, reset = 1'b1;
   logic a_ready, a_valid = 1'b0, a_corrupt = 1'b0, d_ready = 1'b0;
   logic [2:0] a_opcode = 3'd0, a_param = 3'd0;
   logic [1:0] a_size = 2'd0;
   logic [8:0] a_source = 9'd0;
   logic [30:0] a_address = 31'd0;
   logic [7:0] a_mask = 8'd0;
   logic [63:0] a_data = 64'd0;
   logic d_valid, d_sink, d_denied, d_corrupt;
   logic [2:0] d_opcode;
   logic [1:0] d_param, d_size;
   logic [8:0] d_source;
   logic [63:0] d_data;
   int errors = 0, checks = 0;
   logic [63:0] ref_mem [DEPTH];
   logic [82:0] exp_q [$];

   tl_ul_ram_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset),
      .auto_in_a_ready(a_ready), .auto_in_a_valid(a_valid),
      .auto_in_a_bits_opcode(a_opcode), .auto_in_a_bits_param(a_param),
      .auto_in_a_bits_size(a_size), .auto_in_a_bits_source(a_source),
      .auto_in_a_bits_address(a_address), .auto_in_a_bits_mask(a_mask),
      .auto_in_a_bits_data(a_data), .auto_in_a_bits_corrupt(a_corrupt),
      .auto_in_d_ready(d_ready), .auto_in_d_valid(d_valid),
      .auto_in_d_bits_opcode(d_opcode), .auto_in_d_bits_param(d_param),
      .auto_in_d_bits_size(d_size), .auto_in_d_bits_source(d_source),
      .auto_in_d_bits_sink(d_sink), .auto_in_d_bits_denied(d_denied),
      .auto_in_d_bits_data(d_data), .auto_in_d_bits_corrupt(d_corrupt));

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [82:0] got, input logic [82:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [82:0] dut_d();
      return {d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data};
   endfunction

   task automatic req(input bit v, input logic [2:0] op, input logic [30:0] addr,
                      input logic [7:0] mask, input logic [63:0] data,
                      input logic [8:0] src, input logic cor);
      a_valid = v; a_opcode = op; a_address = addr; a_mask = mask;
      a_data = data; a_source = src; a_corrupt = cor; a_size = 2'd3;
      a_param = 3'($urandom);
   endtask

   function automatic logic [30:0] word_addr(input int off);
      return 31'(int'(BASE) + off * 8);
   endfunction

   // Expected response and memory effect of the request currently on A.
   task automatic model_fire(output logic [82:0] r);
      int off;
      bit inr;
      logic [63:0] w;
      logic [2:0] op;
      logic den, cor;
      off = int'(a_address >> 3) - int'(BASE >> 3);
      inr = off >= 0 && off < DEPTH;
      w = 64'd0;
      if (inr) w = ref_mem[off];
      case (a_opcode)
         3'd0, 3'd1: begin op = 3'd0; den = !inr; cor = 1'b0; w = 64'd0; end
         3'd4: begin op = 3'd1; den = !inr; cor = !inr; end
         3'd2, 3'd3: begin op = 3'd1; den = 1'b1; cor = 1'b1; w = 64'd0; end
         3'd5: begin op = 3'd2; den = 1'b0; cor = 1'b0; w = 64'd0; end
         default: begin op = 3'd0; den = 1'b1; cor = 1'b0; w = 64'd0; end
      endcase
      r = {op, 2'd0, a_size, a_source, 1'b0, den, cor, w};
      if (a_opcode <= 3'd1 && inr && !a_corrupt)
         for (int i = 0; i < 8; i++)
            if (a_mask[i]) ref_mem[off][8*i +: 8] = a_data[8*i +: 8];
   endtask

   // Inputs are set just after a falling edge; check, advance the model, move to next falling edge.
   task automatic cycle();
      logic [82:0] r;
      bit af, df;
      #1;
      chk("a_ready", 83'(a_ready), 83'(exp_q.size() == 0 || d_ready));
      chk("d_valid", 83'(d_valid), 83'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("d_payload", dut_d(), exp_q[0]);
      df = exp_q.size() != 0 && d_ready;
      af = a_valid && (exp_q.size() == 0 || d_ready);
      r = 83'd0;
      if (af) model_fire(r);
      if (df) void'(exp_q.pop_front());
      if (af) exp_q.push_back(r);
      @(negedge clock);
   endtask

   initial begin
      #1 reset = 1'b0;
      #1;
      chk("rst_d_valid", 83'(d_valid), 83'd0);
      chk("rst_a_ready", 83'(a_ready), 83'd1);
      chk("rst_payload", dut_d(), 83'd0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      d_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         req(1, 3'd0, word_addr(i), 8'hFF, {$urandom, $urandom}, 9'($urandom), 1'b0);
         cycle();
      end
      // reset while a response is pending and stalled
      d_ready = 1'b0;
      req(1, 3'd4, word_addr(0), 8'h00, 64'd0, 9'h3, 1'b0);
      cycle();
      req(0, 3'd4, word_addr(0), 8'h00, 64'd0, 9'h3, 1'b0);
      #2 reset = 1'b0;
      #1;
      chk("async_rst_d_valid", 83'(d_valid), 83'd0);
      chk("async_rst_a_ready", 83'(a_ready), 83'd1);
      chk("async_rst_payload", dut_d(), 83'd0);
      exp_q.delete();
      @(negedge clock);
      reset = 1'b1;
      d_ready = 1'b1;
      req(1, 3'd0, BASE + 31'h10, 8'hFF, 64'h1122334455667788, 9'h1A5, 1'b0);
      cycle();
      req(1, 3'd4, BASE + 31'h10, 8'h00, 64'd0, 9'h0B, 1'b0);
      #1;
      chk("putfull_ack", 83'({d_valid, d_opcode, d_source, d_denied}), 83'({1'b1, 3'd0, 9'h1A5, 1'b0}));
      cycle();
      req(1, 3'd1, BASE + 31'h10, 8'h0F, 64'hFFFFFFFF_AAAAAAAA, 9'h0C, 1'b0);
      #1;
      chk("get_data", 83'({d_opcode, d_data}), 83'({3'd1, 64'h1122334455667788}));
      cycle();
      req(1, 3'd4, BASE + 31'h10, 8'h00, 64'd0, 9'h0D, 1'b0);
      cycle();
      req(0, 3'd4, BASE + 31'h10, 8'h00, 64'd0, 9'h0D, 1'b0);
      #1;
      chk("partial_data", 83'(d_data), 83'(64'h11223344AAAAAAAA));
      cycle();
      for (int i = 1; i <= 4; i++) begin
         req(1, 3'd4, word_addr(i), 8'h00, 64'd0, 9'(i), 1'b0);
         cycle();
      end
      d_ready = 1'b0;
      req(1, 3'd4, word_addr(5), 8'h00, 64'd0, 9'h5, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1 chk("stall_a_ready", 83'(a_ready), 83'd0);
         cycle();
      end
      d_ready = 1'b1;
      req(1, 3'd4, word_addr(DEPTH), 8'h00, 64'd0, 9'h20, 1'b0);
      cycle();
      req(1, 3'd0, word_addr(DEPTH), 8'hFF, 64'hDEAD, 9'h21, 1'b0);
      #1;
      chk("oor_get", 83'({d_opcode, d_denied, d_corrupt, d_data}), 83'({3'd1, 1'b1, 1'b1, 64'd0}));
      cycle();
      req(1, 3'd4, word_addr(DEPTH - 1), 8'h00, 64'd0, 9'h22, 1'b0);
      #1;
      chk("oor_put", 83'({d_opcode, d_denied}), 83'({3'd0, 1'b1}));
      cycle();
      req(1, 3'd2, word_addr(7), 8'hFF, 64'h5555, 9'h23, 1'b0);
      cycle();
      req(1, 3'd5, word_addr(7), 8'h00, 64'd0, 9'h24, 1'b0);
      #1;
      chk("arith", 83'({d_opcode, d_denied, d_corrupt}), 83'({3'd1, 1'b1, 1'b1}));
      cycle();
      req(1, 3'd0, word_addr(7), 8'hFF, 64'h7777, 9'h25, 1'b1);
      #1;
      chk("hint", 83'({d_opcode, d_denied}), 83'({3'd2, 1'b0}));
      cycle();
      req(1, 3'd4, word_addr(7), 8'h00, 64'd0, 9'h26, 1'b0);
      cycle();
      req(1, 3'd7, word_addr(7), 8'h00, 64'd0, 9'h27, 1'b0);
      cycle();
      for (int n = 0; n < 3000; n++) begin
         int off;
         off = int'($urandom_range(0, 539)) - 10;
         req($urandom_range(0, 3) != 0, 3'($urandom), 31'(int'(word_addr(off)) + int'($urandom_range(0, 7))),
             8'($urandom), {$urandom, $urandom}, 9'($urandom), $urandom_range(0, 9) == 0);
         if ($urandom_range(0, 1) == 0) a_opcode = $urandom_range(0, 1) == 0 ? 3'd4 : 3'd0;
         a_size = 2'($urandom);
         d_ready = $urandom_range(0, 9) < 7;
         cycle();
      end
      a_valid = 1'b0;
      d_ready = 1'b1;
      cycle();
      cycle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
